pipe_hazard_ctrl: RTL and testbench

- Central stall/flush controller for the five-stage MIPS pipeline.
- Decides each cycle whether the F stage (PC) and the F/D register hold, whether the D/E register loads a bubble, and whether the whole pipeline is redirected by an exception/interrupt request.
- Owns the multiply/divide busy timer, so HI/LO readers in D wait for an in-flight mult/div.
- Keeps a saturating count of stall cycles for performance debug.

---
 rtl/pipe_hazard_ctrl_if.sv | 42 ++++
 rtl/pipe_hazard_ctrl.sv | 75 +++++++
 tb/tb_pipe_hazard_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the five-stage pipeline (master) and the stall/flush controller (slave).
// Carries the D/E/M hazard inputs and the hold/bubble/flush decisions back to the pipeline.
interface pipe_hazard_ctrl_if #(
  parameter int PERF_W = 32
);
  logic [4:0]        rs_D;
  logic [4:0]        rt_D;
  logic [1:0]        tuse_rs_D;
  logic [1:0]        tuse_rt_D;
  logic              uses_md_D;
  logic              eret_D;
  logic [4:0]        a3_E;
  logic [1:0]        tnew_E;
  logic [4:0]        a3_M;
  logic [1:0]        tnew_M;
  logic              mtc0_epc_E;
  logic              mtc0_epc_M;
  logic              md_start_E;
  logic              md_is_div_E;
  logic              req;
  logic              hold_F;
  logic              hold_FD;
  logic              bubble_DE;
  logic              req_flush;
  logic              md_busy;
  logic [3:0]        md_count;
  logic [PERF_W-1:0] stall_cycles;

  modport master (
    output rs_D, rt_D, tuse_rs_D, tuse_rt_D, uses_md_D, eret_D,
           a3_E, tnew_E, a3_M, tnew_M, mtc0_epc_E, mtc0_epc_M,
           md_start_E, md_is_div_E, req,
    input  hold_F, hold_FD, bubble_DE, req_flush, md_busy, md_count, stall_cycles
  );

  modport slave (
    input  rs_D, rt_D, tuse_rs_D, tuse_rt_D, uses_md_D, eret_D,
           a3_E, tnew_E, a3_M, tnew_M, mtc0_epc_E, mtc0_epc_M,
           md_start_E, md_is_div_E, req,
    output hold_F, hold_FD, bubble_DE, req_flush, md_busy, md_count, stall_cycles
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the five-stage MIPS pipeline: data, HI/LO and ERET hazards,
// exception redirect priority, the mult/div busy timer and a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
  parameter int PERF_W   = 32
) (
  input logic              clk,
  input logic              reset,
  pipe_hazard_ctrl_if.slave bus
);

  localparam logic [3:0] MULT_LD = 4'(MULT_CYC);
  localparam logic [3:0] DIV_LD  = 4'(DIV_CYC);

  logic [3:0]        md_count;
  logic [PERF_W-1:0] stall_cycles;
  logic              stall_rs;
  logic              stall_rt;
  logic              stall_md;
  logic              stall_eret;
  logic              stall;
  logic              md_busy;

  // A source stalls when an older producer of the same register delivers later than D needs it;
  // tuse = 3 can never be below a 2-bit tnew, so "not read" falls out of the compare.
  function automatic logic data_stall(input logic [4:0] src, input logic [1:0] tuse,
                                      input logic [4:0] a3_e, input logic [1:0] tnew_e,
                                      input logic [4:0] a3_m, input logic [1:0] tnew_m);
    return (src != 5'd0) &&
           (((src == a3_e) && (tuse < tnew_e)) || ((src == a3_m) && (tuse < tnew_m)));
  endfunction

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + PERF_W'(1);
  endfunction

  always_comb begin
    stall_rs   = data_stall(bus.rs_D, bus.tuse_rs_D, bus.a3_E, bus.tnew_E, bus.a3_M, bus.tnew_M);
    stall_rt   = data_stall(bus.rt_D, bus.tuse_rt_D, bus.a3_E, bus.tnew_E, bus.a3_M, bus.tnew_M);
    md_busy    = bus.md_start_E || (md_count != 4'd0);
    stall_md   = bus.uses_md_D && md_busy;
    stall_eret = bus.eret_D && (bus.mtc0_epc_E || bus.mtc0_epc_M);
    stall      = stall_rs || stall_rt || stall_md || stall_eret;
  end

  // Redirect wins over every stall: the flushed instructions no longer need to wait.
  assign bus.hold_F       = stall && !bus.req;
  assign bus.hold_FD      = stall && !bus.req;
  assign bus.bubble_DE    = stall && !bus.req;
  assign bus.req_flush    = bus.req;
  assign bus.md_busy      = md_busy;
  assign bus.md_count     = md_count;
  assign bus.stall_cycles = stall_cycles;

  // A start alongside req belongs to a squashed instruction; a running count is committed work.
  always_ff @(posedge clk) begin
    if (reset) begin
      md_count <= 4'd0;
    end else if (bus.md_start_E && !bus.req) begin
      md_count <= bus.md_is_div_E ? DIV_LD : MULT_LD;
    end else if (md_count != 4'd0) begin
      md_count <= md_count - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (stall && !bus.req) begin
      stall_cycles <= sat_inc(stall_cycles);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed hazard scenarios followed by random traffic,
// expectations from a cycle-indexed reference model, compared by an independent negedge monitor.
module tb_pipe_hazard_ctrl;

  localparam int MULT_CYC = 5;
  localparam int DIV_CYC  = 10;
  localparam longint PMAX = 64'hFFFF_FFFF;

  typedef struct {
    bit     hold;
    bit     flush;
    bit     busy;
    int     cnt;
    longint perf;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  pipe_hazard_ctrl_if #(.PERF_W(32)) bus ();

  pipe_hazard_ctrl #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC), .PERF_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t   sb[$];
  int     total  = 0;
  int     passed = 0;
  int     t      = 0;   // index of the current cycle
  int     md_zero_at = 0; // first cycle index at which the mult/div count reads 0
  longint perf   = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s at t=%0t: got %0d expected %0d", nm, $time, act, exp);
  endtask

  // Monitor: every cycle the DUT presents its decisions; compare with the oldest expectation.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("hold_F",       longint'(bus.hold_F),       longint'(e.hold));
      chk("hold_FD",      longint'(bus.hold_FD),      longint'(e.hold));
      chk("bubble_DE",    longint'(bus.bubble_DE),    longint'(e.hold));
      chk("req_flush",    longint'(bus.req_flush),    longint'(e.flush));
      chk("md_busy",      longint'(bus.md_busy),      longint'(e.busy));
      chk("md_count",     longint'(bus.md_count),     longint'(e.cnt));
      chk("stall_cycles", longint'(bus.stall_cycles), e.perf);
    end
  end

  function automatic bit needs_stall(input logic [4:0] src, input logic [1:0] tuse);
    logic [4:0] dst [2];
    logic [1:0] tn  [2];
    bit s;
    dst[0] = bus.a3_E; tn[0] = bus.tnew_E;
    dst[1] = bus.a3_M; tn[1] = bus.tnew_M;
    s = 0;
    if (src != 0)
      for (int k = 0; k < 2; k++)
        if (dst[k] == src && int'(tuse) < int'(tn[k])) s = 1;
    return s;
  endfunction

  // Predict this cycle's outputs from the current inputs, advance the model across the edge.
  task automatic step(input bit check);
    exp_t e;
    int   cnt;
    bit   busy, stall;
    cnt   = (md_zero_at > t) ? md_zero_at - t : 0;
    busy  = bus.md_start_E || cnt > 0;
    stall = needs_stall(bus.rs_D, bus.tuse_rs_D) || needs_stall(bus.rt_D, bus.tuse_rt_D) ||
            (bus.uses_md_D && busy) || (bus.eret_D && (bus.mtc0_epc_E || bus.mtc0_epc_M));
    e.hold  = stall && !bus.req;
    e.flush = bus.req;
    e.busy  = busy;
    e.cnt   = cnt;
    e.perf  = perf;
    if (check) sb.push_back(e);
    if (reset) begin
      md_zero_at = 0;
      perf       = 0;
    end else begin
      if (bus.md_start_E && !bus.req) md_zero_at = t + 1 + (bus.md_is_div_E ? DIV_CYC : MULT_CYC);
      if (stall && !bus.req && perf < PMAX) perf++;
    end
    t++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.rs_D = 0; bus.rt_D = 0; bus.tuse_rs_D = 3; bus.tuse_rt_D = 3;
    bus.uses_md_D = 0; bus.eret_D = 0;
    bus.a3_E = 0; bus.tnew_E = 0; bus.a3_M = 0; bus.tnew_M = 0;
    bus.mtc0_epc_E = 0; bus.mtc0_epc_M = 0;
    bus.md_start_E = 0; bus.md_is_div_E = 0; bus.req = 0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    step(0);
    step(1);
    reset = 1'b0;
    step(1);

    // lw hazard in E, then the same producer in M, then its data ready
    bus.a3_E = 8; bus.tnew_E = 2; bus.rs_D = 8; bus.tuse_rs_D = 0; step(1);
    bus.a3_E = 0; bus.tnew_E = 0; bus.a3_M = 8; bus.tnew_M = 1; step(1);
    bus.tnew_M = 0; step(1);
    idle();

    // $0 never stalls; tuse = 3 never stalls
    bus.rs_D = 0; bus.a3_E = 0; bus.tnew_E = 2; bus.tuse_rs_D = 0; step(1);
    bus.rt_D = 9; bus.a3_E = 9; bus.tnew_E = 2; bus.tuse_rt_D = 3; step(1);
    idle();

    // mult then mflo waiting in D
    bus.md_start_E = 1; bus.uses_md_D = 1; step(1);
    bus.md_start_E = 0;
    for (int i = 0; i < 7; i++) step(1);
    idle();

    // div started together with req is squashed
    bus.md_start_E = 1; bus.md_is_div_E = 1; bus.req = 1; bus.uses_md_D = 1; step(1);
    idle(); step(1);
    // div started a cycle earlier keeps counting through req
    bus.md_start_E = 1; bus.md_is_div_E = 1; step(1);
    idle(); bus.req = 1; step(1);
    bus.req = 0; step(1);

    // eret behind mtc0 EPC in E, then in M, then released
    idle(); bus.eret_D = 1; bus.mtc0_epc_E = 1; step(1);
    bus.mtc0_epc_E = 0; bus.mtc0_epc_M = 1; step(1);
    bus.mtc0_epc_M = 0; step(1);
    idle();
    for (int i = 0; i < 12; i++) step(1);

    // reset while a div is mid-count
    bus.md_start_E = 1; bus.md_is_div_E = 1; step(1);
    idle(); step(1); step(1); step(1);
    reset = 1'b1; step(1);
    reset = 1'b0; step(1);

    // random traffic over a small register space so hazards are frequent
    for (int i = 0; i < 400; i++) begin
      bus.rs_D        = 5'($urandom_range(0, 3));
      bus.rt_D        = 5'($urandom_range(0, 3));
      bus.tuse_rs_D   = 2'($urandom_range(0, 3));
      bus.tuse_rt_D   = 2'($urandom_range(0, 3));
      bus.a3_E        = 5'($urandom_range(0, 3));
      bus.tnew_E      = 2'($urandom_range(0, 3));
      bus.a3_M        = 5'($urandom_range(0, 3));
      bus.tnew_M      = 2'($urandom_range(0, 3));
      bus.uses_md_D   = ($urandom_range(0, 2) == 0);
      bus.eret_D      = ($urandom_range(0, 7) == 0);
      bus.mtc0_epc_E  = ($urandom_range(0, 5) == 0);
      bus.mtc0_epc_M  = ($urandom_range(0, 5) == 0);
      bus.md_start_E  = ($urandom_range(0, 7) == 0);
      bus.md_is_div_E = 1'($urandom_range(0, 1));
      bus.req         = ($urandom_range(0, 9) == 0);
      reset           = ($urandom_range(0, 49) == 0);
      step(1);
    end
    reset = 1'b0;
    idle();

    for (int i = 0; i < 4 && sb.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    chk("scoreboard_drained", longint'(sb.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
